dmem_responder: RTL and testbench

Data-memory responder serving the load/store requests the MIPS datapath issues from its Mem stage. It accepts one request at a time over a valid/ready-style address handshake and holds it for a programmable number of cycles to model SRAM/bus latency. It then returns a single-cycle `data_ok` response. Lane steering happens here, on the memory side:
- store data arrives low-aligned and is shifted into the addressed byte lane(s);
- load data is returned right-aligned and zero-filled, so the writeback stage only applies sign or zero extension.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_if.sv | 17 +
 rtl/dmem_ram_1p.sv | 21 ++
 rtl/dmem_responder.sv | 122 ++++++++++++
 tb/tb_dmem_responder.sv | 139 +++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Size encodings, FSM states and the byte-enable decoder.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Reserved size yields no enabled lanes.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_BYTE: be = 4'b0001 << a;
      SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between the Mem stage (master) and the responder (slave).
interface dmem_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, wr, size, addr, wdata,
                  input  addr_ok, data_ok, rdata, err);
  modport slave  (input  req, wr, size, addr, wdata,
                  output addr_ok, data_ok, rdata, err);
endinterface

// File: rtl/dmem_ram_1p.sv
// Single-port word array with per-byte write enable and registered read data.
module dmem_ram_1p #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Latency-modelling data-memory responder with memory-side lane steering.
// Store data is lane-shifted in; load data is returned right-aligned and zero-filled.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        wr_l;
  logic [1:0]  size_l;
  logic [31:0] addr_l;
  logic [31:0] wdata_l;
  logic [31:0] rdata_hold;

  logic              fault;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;
  logic [31:0]       shifted;
  logic [31:0]       rdata_resp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      wr_l       <= 1'b0;
      size_l     <= SZ_BYTE;
      addr_l     <= 32'd0;
      wdata_l    <= 32'd0;
      rdata_hold <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && bus.req) begin
        wr_l    <= bus.wr;
        size_l  <= bus.size;
        addr_l  <= bus.addr;
        wdata_l <= bus.wdata;
      end
      if (state == RESP && !wr_l) rdata_hold <= rdata_resp;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (bus.req) begin
          if (LATENCY == 1) begin
            state_nx = RESP;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nx = RESP;
        else             cnt_nx   = cnt - 4'd1;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign fault = (size_l == 2'd3)
               | (size_l == SZ_HALF && addr_l[0])
               | (size_l == SZ_WORD && addr_l[1:0] != 2'b00)
               | (|addr_l[31:ADDR_W+2]);

  // In IDLE the array is addressed from the live bus so a LATENCY=1 load
  // has its word ready on the edge that enters RESP.
  assign ram_addr = (state == IDLE) ? bus.addr[ADDR_W+1:2] : addr_l[ADDR_W+1:2];
  assign ram_we   = (state == RESP && wr_l && !fault) ? byte_en(size_l, addr_l[1:0]) : 4'b0000;

  always_comb begin
    ram_wdata = wdata_l;
    case (size_l)
      SZ_BYTE: ram_wdata = {4{wdata_l[7:0]}};
      SZ_HALF: ram_wdata = {2{wdata_l[15:0]}};
      default: ram_wdata = wdata_l;
    endcase
  end

  dmem_ram_1p #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  assign shifted = ram_q >> {addr_l[1:0], 3'b000};

  always_comb begin
    rdata_resp = 32'd0;
    if (!fault) begin
      case (size_l)
        SZ_BYTE: rdata_resp = {24'd0, shifted[7:0]};
        SZ_HALF: rdata_resp = {16'd0, shifted[15:0]};
        default: rdata_resp = ram_q;
      endcase
    end
  end

  assign bus.addr_ok = (state == IDLE);
  assign bus.data_ok = (state == RESP);
  assign bus.err     = (state == RESP) && fault;
  assign bus.rdata   = (state == RESP && !wr_l) ? rdata_resp : rdata_hold;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: three responders (LATENCY 2, 1, 15) on one clock and reset.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_if b2 ();
  dmem_if b1 ();
  dmem_if b15 ();

  dmem_responder #(.ADDR_W(10), .LATENCY(2))  dut2  (.clk(clk), .rst(rst), .bus(b2));
  dmem_responder #(.ADDR_W(10), .LATENCY(1))  dut1  (.clk(clk), .rst(rst), .bus(b1));
  dmem_responder #(.ADDR_W(10), .LATENCY(15)) dut15 (.clk(clk), .rst(rst), .bus(b15));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access on the LATENCY=2 responder; the bus inputs are scrambled
  // right after acceptance so only the latched request may matter.
  task automatic acc2(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input string tag, input logic exp_err,
                      input logic chk_rd, input logic [31:0] exp_rd);
    int cyc;
    @(negedge clk);
    chk({tag, "_addr_ok"}, {31'd0, b2.addr_ok}, 32'd1);
    b2.req = 1'b1; b2.wr = wr; b2.size = sz; b2.addr = a; b2.wdata = wd;
    @(posedge clk);
    #1;
    b2.req = 1'b0; b2.wr = ~wr; b2.size = ~sz; b2.addr = a ^ 32'h4; b2.wdata = ~wd;
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (b2.data_ok) begin
        cyc = i;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(cyc), 32'd2);
    chk({tag, "_err"}, {31'd0, b2.err}, {31'd0, exp_err});
    if (chk_rd) chk({tag, "_rdata"}, b2.rdata, exp_rd);
    @(negedge clk);
    chk({tag, "_dok_drop"}, {30'd0, b2.data_ok, b2.err}, 32'd0);
  endtask

  int acc1, acc15, nd1, nd15;

  initial begin
    b2.req = 0;  b2.wr = 0;  b2.size = SZ_WORD;  b2.addr = 0;  b2.wdata = 0;
    b1.req = 0;  b1.wr = 0;  b1.size = SZ_WORD;  b1.addr = 0;  b1.wdata = 0;
    b15.req = 0; b15.wr = 0; b15.size = SZ_WORD; b15.addr = 0; b15.wdata = 0;

    repeat (2) @(negedge clk);
    chk("rst_addr_ok", {31'd0, b2.addr_ok}, 32'd1);
    chk("rst_data_ok", {31'd0, b2.data_ok}, 32'd0);
    chk("rst_rdata",   b2.rdata,            32'd0);
    chk("rst_err",     {31'd0, b2.err},     32'd0);
    rst = 1'b0;

    acc2(1, SZ_WORD, 32'h10, 32'hDEADBEEF, "sw10",  0, 0, 0);
    acc2(0, SZ_WORD, 32'h10, 32'h0, "lw10",  0, 1, 32'hDEADBEEF);
    acc2(1, SZ_BYTE, 32'h13, 32'h000000AA, "sb13",  0, 1, 32'hDEADBEEF);
    acc2(0, SZ_WORD, 32'h10, 32'h0, "lw10b", 0, 1, 32'hAAADBEEF);
    acc2(0, SZ_BYTE, 32'h11, 32'h0, "lb11",  0, 1, 32'h000000BE);
    acc2(0, SZ_HALF, 32'h12, 32'h0, "lh12",  0, 1, 32'h0000AAAD);

    acc2(0, SZ_WORD, 32'h12, 32'h0, "lw12_mis", 1, 1, 32'h0);
    acc2(1, SZ_HALF, 32'h11, 32'h0000FFFF, "sh11_mis", 1, 0, 0);
    acc2(0, SZ_WORD, 32'h10, 32'h0, "lw10_c", 0, 1, 32'hAAADBEEF);
    acc2(1, 2'd3,    32'h10, 32'h00000000, "sz3", 1, 0, 0);
    acc2(0, SZ_WORD, 32'h10, 32'h0, "lw10_d", 0, 1, 32'hAAADBEEF);
    acc2(0, SZ_WORD, 32'h1000, 32'h0, "lw1000_oob", 1, 1, 32'h0);
    acc2(1, SZ_WORD, 32'h1010, 32'h0, "sw1010_oob", 1, 0, 0);
    acc2(0, SZ_WORD, 32'h10, 32'h0, "lw10_e", 0, 1, 32'hAAADBEEF);

    // A store response must leave the last load data visible.
    acc2(1, SZ_WORD, 32'h30, 32'h11111111, "sw30_hold", 0, 1, 32'hAAADBEEF);
    acc2(0, SZ_WORD, 32'h30, 32'h0, "lw30", 0, 1, 32'h11111111);

    acc2(1, SZ_WORD, 32'h20, 32'hCAFEF00D, "sw20", 0, 0, 0);
    @(negedge clk);
    b2.req = 1'b1; b2.wr = 1'b1; b2.size = SZ_WORD; b2.addr = 32'h20; b2.wdata = 32'h12345678;
    @(posedge clk);
    #1;
    b2.req = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_addr_ok", {31'd0, b2.addr_ok}, 32'd1);
    chk("mid_rst_data_ok", {31'd0, b2.data_ok}, 32'd0);
    chk("mid_rst_rdata",   b2.rdata,            32'd0);
    chk("mid_rst_err",     {31'd0, b2.err},     32'd0);
    @(negedge clk);
    rst = 1'b0;
    acc2(0, SZ_WORD, 32'h20, 32'h0, "lw20_after_rst", 0, 1, 32'hCAFEF00D);

    // Latency sweep: req held high; iteration c samples after edge c.
    acc1 = -100; acc15 = -100; nd1 = 0; nd15 = 0;
    @(negedge clk);
    b1.req = 1'b1;  b1.wr = 1'b0;  b1.size = SZ_WORD;  b1.addr = 32'h0;
    b15.req = 1'b1; b15.wr = 1'b0; b15.size = SZ_WORD; b15.addr = 32'h0;
    for (int c = 0; c < 70; c++) begin
      if (b1.data_ok) begin
        nd1++;
        chk("l1_dok_gap", 32'(c - acc1), 32'd0);
      end
      if (b1.addr_ok) begin
        if (acc1 >= 0) chk("l1_acc_gap", 32'(c + 1 - acc1), 32'd2);
        acc1 = c + 1;
      end
      if (b15.data_ok) begin
        nd15++;
        chk("l15_dok_gap", 32'(c - acc15), 32'd14);
      end
      if (b15.addr_ok) begin
        if (acc15 >= 0) chk("l15_acc_gap", 32'(c + 1 - acc15), 32'd16);
        acc15 = c + 1;
      end
      @(negedge clk);
    end
    b1.req = 1'b0;
    b15.req = 1'b0;
    chk("l1_resp_count",  32'(nd1),  32'd35);
    chk("l15_resp_count", 32'(nd15), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
